multicycle_controller: RTL and testbench

- Next-generation MIPS control unit: a multicycle FSM sequencing fetch, decode, execute, memory and writeback over several clocks.
- Replaces the single-cycle combinational decoder; drives a shared-ALU, single-memory datapath.
- Adds a memory ready/wait handshake and BNE/NOR under a mode parameter.
- Adds a retired-instruction counter.

---
 rtl/multicycle_controller_pkg.sv | 66 ++++++
 rtl/multicycle_controller_aludec.sv | 43 ++++
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct fields and datapath select codes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_AND   = 3'd2,
        ALUOP_OR    = 3'd3,
        ALUOP_FUNCT = 3'd4
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] IMM_SIGN  = 2'b00;
    localparam logic [1:0] IMM_ZERO  = 2'b01;
    localparam logic [1:0] IMM_UPPER = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps an operation class (or the R-type funct field) to the
// ALU control code and reports whether the funct field is supported.
module mc_aludec
    import multicycle_controller_pkg::*;
#(
    parameter int EXT_ISA = 1
) (
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [3:0]  alucontrol,
    output logic        funct_legal
);

    logic [3:0] funct_ctl;

    always_comb begin
        funct_legal = 1'b1;
        funct_ctl   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            FN_SLT:  funct_ctl = ALU_SLT;
            FN_NOR: begin
                funct_ctl   = ALU_NOR;
                funct_legal = (EXT_ISA != 0);
            end
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_AND:   alucontrol = ALU_AND;
            ALUOP_OR:    alucontrol = ALU_OR;
            ALUOP_FUNCT: alucontrol = funct_ctl;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/
// writeback for a shared-ALU datapath and counts retired instructions.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 when memory is ready
// DECODE | compute branch target, dispatch on opcode
// MEMADR | compute load/store address
// MEMRD  | load data read, waits on mem_ready
// MEMWB  | write load data to rt
// MEMWR  | store write, waits on mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare operands, conditionally take branch
// IMMEX  | immediate ALU operation
// IMMWB  | write ALU result to rt
// JUMP   | load jump target into PC
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int EXT_ISA  = 1,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                iord,
    output logic                irwrite,
    output logic                memwrite,
    output logic                memtoreg,
    output logic                regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          immtype,
    output logic [1:0]          pcsrc,
    output logic                pcen,
    output logic [3:0]          alucontrol,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state_dbg
);

    localparam bit EXT = (EXT_ISA != 0);

    state_t     state;
    state_t     decode_next;
    aluop_t     aluop;
    logic [3:0] alu_ctl;
    logic       funct_legal;
    logic       alu_used;
    logic       retire;

    mc_aludec #(.EXT_ISA(EXT_ISA)) u_aludec (
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (alu_ctl),
        .funct_legal (funct_legal)
    );

    always_comb begin
        decode_next = S_FETCH;
        case (op)
            OP_RTYPE:                         decode_next = funct_legal ? S_EXEC : S_FETCH;
            OP_LW, OP_SW:                     decode_next = S_MEMADR;
            OP_BEQ:                           decode_next = S_BRANCH;
            OP_BNE:                           decode_next = EXT ? S_BRANCH : S_FETCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: decode_next = S_IMMEX;
            OP_J:                             decode_next = S_JUMP;
            default:                          decode_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (state)
            S_MEMWR:                                     retire = mem_ready;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: retire = 1'b1;
            default:                                     retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            if (retire)
                retired <= retired + RETIRE_W'(1);
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: state <= decode_next;
                S_MEMADR: state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_IMMEX:  state <= S_IMMWB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // ALU operation class and immediate format; alucontrol is 0 where unused.
    always_comb begin
        aluop    = ALUOP_ADD;
        alu_used = 1'b0;
        immtype  = IMM_SIGN;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: alu_used = 1'b1;
            S_EXEC: begin
                alu_used = 1'b1;
                aluop    = ALUOP_FUNCT;
            end
            S_BRANCH: begin
                alu_used = 1'b1;
                aluop    = ALUOP_SUB;
            end
            S_IMMEX: begin
                alu_used = 1'b1;
                case (op)
                    OP_ANDI: begin aluop = ALUOP_AND; immtype = IMM_ZERO;  end
                    OP_ORI:  begin aluop = ALUOP_OR;  immtype = IMM_ZERO;  end
                    OP_LUI:  begin aluop = ALUOP_OR;  immtype = IMM_UPPER; end
                    default: begin aluop = ALUOP_ADD; immtype = IMM_SIGN;  end
                endcase
            end
            default: ;
        endcase
    end

    assign alucontrol = alu_used ? alu_ctl : 4'b0000;
    assign state_dbg  = state;
    assign illegal_op = (state == S_DECODE) && (decode_next == S_FETCH);

    always_comb begin
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        pcsrc    = PC_ALU;
        pcen     = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: alusrca = 1'b1;
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = PC_ALUOUT;
                pcen    = (EXT && op == OP_BNE) ? ~zero : zero;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_IMMWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = PC_JUMP;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: three controller instances (extended ISA, base ISA,
// 3-bit retire counter) checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] immtype;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [3:0] alucontrol;
        logic       illegal_op;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    ctrl_t       ctl_a, ctl_b, ctl_c;
    logic [31:0] ret_a, ret_b;
    logic [2:0]  ret_c;
    logic [3:0]  st_a, st_b, st_c;

    int          sel;
    ctrl_t       obs_ctl;
    logic [3:0]  obs_st;
    logic [31:0] obs_ret;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_ret;
    int          memwrite_cycles;

    logic [5:0]  op_list[11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001100, 6'b001101, 6'b001111, 6'b000010,
                                 6'b111111};
    logic [5:0]  fn_list[6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

    always #5 clk = ~clk;

    multicycle_controller #(.EXT_ISA(1), .RETIRE_W(32)) dut_a (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(ctl_a.iord), .irwrite(ctl_a.irwrite), .memwrite(ctl_a.memwrite),
        .memtoreg(ctl_a.memtoreg), .regdst(ctl_a.regdst), .regwrite(ctl_a.regwrite),
        .alusrca(ctl_a.alusrca), .alusrcb(ctl_a.alusrcb), .immtype(ctl_a.immtype),
        .pcsrc(ctl_a.pcsrc), .pcen(ctl_a.pcen), .alucontrol(ctl_a.alucontrol),
        .illegal_op(ctl_a.illegal_op), .retired(ret_a), .state_dbg(st_a)
    );

    multicycle_controller #(.EXT_ISA(0), .RETIRE_W(32)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(ctl_b.iord), .irwrite(ctl_b.irwrite), .memwrite(ctl_b.memwrite),
        .memtoreg(ctl_b.memtoreg), .regdst(ctl_b.regdst), .regwrite(ctl_b.regwrite),
        .alusrca(ctl_b.alusrca), .alusrcb(ctl_b.alusrcb), .immtype(ctl_b.immtype),
        .pcsrc(ctl_b.pcsrc), .pcen(ctl_b.pcen), .alucontrol(ctl_b.alucontrol),
        .illegal_op(ctl_b.illegal_op), .retired(ret_b), .state_dbg(st_b)
    );

    multicycle_controller #(.EXT_ISA(1), .RETIRE_W(3)) dut_c (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(ctl_c.iord), .irwrite(ctl_c.irwrite), .memwrite(ctl_c.memwrite),
        .memtoreg(ctl_c.memtoreg), .regdst(ctl_c.regdst), .regwrite(ctl_c.regwrite),
        .alusrca(ctl_c.alusrca), .alusrcb(ctl_c.alusrcb), .immtype(ctl_c.immtype),
        .pcsrc(ctl_c.pcsrc), .pcen(ctl_c.pcen), .alucontrol(ctl_c.alucontrol),
        .illegal_op(ctl_c.illegal_op), .retired(ret_c), .state_dbg(st_c)
    );

    always_comb begin
        obs_ctl = ctl_a;
        obs_st  = st_a;
        obs_ret = ret_a;
        if (sel == 1) begin
            obs_ctl = ctl_b;
            obs_st  = st_b;
            obs_ret = ret_b;
        end else if (sel == 2) begin
            obs_ctl = ctl_c;
            obs_st  = st_c;
            obs_ret = {29'd0, ret_c};
        end
    end

    // ---------------- reference model ----------------
    function automatic bit funct_ok(input logic [5:0] f, input bit ext);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010) || (ext && f == 6'b100111);
    endfunction

    // 0 illegal, 1 LW, 2 SW, 3 R-type, 4 branch, 5 immediate, 6 jump
    function automatic int instr_class(input logic [5:0] o, input logic [5:0] f, input bit ext);
        case (o)
            6'b000000: return funct_ok(f, ext) ? 3 : 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 4;
            6'b000101: return ext ? 4 : 0;
            6'b001000, 6'b001100, 6'b001101, 6'b001111: return 5;
            6'b000010: return 6;
            default:   return 0;
        endcase
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input int s, input logic [5:0] o, input logic [5:0] f,
                                       input logic z, input logic mr, input bit ill);
        ctrl_t e;
        e = '0;
        case (s)
            0: begin e.alusrcb = 2'b01; e.alucontrol = 4'b0010; e.irwrite = mr; e.pcen = mr; end
            1: begin e.alusrcb = 2'b11; e.alucontrol = 4'b0010; e.illegal_op = ill; end
            2: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 4'b0010; end
            3: e.iord = 1'b1;
            4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5: begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6: begin e.alusrca = 1'b1; e.alucontrol = funct_alu(f); end
            7: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8: begin
                e.alusrca = 1'b1; e.alucontrol = 4'b0110; e.pcsrc = 2'b01;
                e.pcen = (o == 6'b000101) ? ~z : z;
            end
            9: begin
                e.alusrca = 1'b1; e.alusrcb = 2'b10;
                case (o)
                    6'b001100: begin e.immtype = 2'b01; e.alucontrol = 4'b0000; end
                    6'b001101: begin e.immtype = 2'b01; e.alucontrol = 4'b0001; end
                    6'b001111: begin e.immtype = 2'b10; e.alucontrol = 4'b0001; end
                    default:   begin e.immtype = 2'b00; e.alucontrol = 4'b0010; end
                endcase
            end
            10: e.regwrite = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_ret = 32'd0;
    endtask

    // Runs one instruction on the selected instance from FETCH back to FETCH.
    // fw/mw are the number of mem_ready=0 wait cycles in FETCH and in the memory state.
    task automatic run_instr(input string name, input logic [5:0] op_i, input logic [5:0] fn_i,
                             input logic z_i, input int fw, input int mw);
        int    path[$];
        int    c;
        bit    ext;
        bit    last;
        ctrl_t e;
        ext   = (sel != 1);
        c     = instr_class(op_i, fn_i, ext);
        op    = op_i;
        funct = fn_i;
        zero  = z_i;
        repeat (fw + 1) path.push_back(0);
        path.push_back(1);
        case (c)
            1: begin path.push_back(2); repeat (mw + 1) path.push_back(3); path.push_back(4); end
            2: begin path.push_back(2); repeat (mw + 1) path.push_back(5); end
            3: begin path.push_back(6); path.push_back(7); end
            4: path.push_back(8);
            5: begin path.push_back(9); path.push_back(10); end
            6: path.push_back(11);
            default: ;
        endcase
        for (int i = 0; i < path.size(); i++) begin
            last = (i == path.size() - 1);
            if (!last) last = (path[i + 1] != path[i]);
            if (path[i] == 0 || path[i] == 3 || path[i] == 5)
                mem_ready = last;
            else
                mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            e = exp_ctrl(path[i], op_i, fn_i, z_i, mem_ready, c == 0);
            checks++;
            if (obs_st !== 4'(path[i])) begin
                failures++;
                $display("FAIL %s state cycle %0d: got %0d want %0d", name, i, obs_st, path[i]);
            end
            checks++;
            if (obs_ctl !== e) begin
                failures++;
                $display("FAIL %s ctrl in state %0d: got %h want %h", name, path[i], obs_ctl, e);
            end
            checks++;
            if (obs_ret !== exp_ret) begin
                failures++;
                $display("FAIL %s retired mid-instr: got %0d want %0d", name, obs_ret, exp_ret);
            end
            if (obs_ctl.memwrite === 1'b1) memwrite_cycles++;
            @(posedge clk);
            #1;
        end
        if (c != 0) exp_ret = (sel == 2) ? ((exp_ret + 1) & 32'h7) : (exp_ret + 1);
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_st !== 4'd0) begin
            failures++;
            $display("FAIL %s end state: got %0d want 0", name, obs_st);
        end
        checks++;
        if (obs_ret !== exp_ret) begin
            failures++;
            $display("FAIL %s retired: got %0d want %0d", name, obs_ret, exp_ret);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctrl_t e;
        sel       = 0;
        reset     = 1'b1;
        op        = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e = exp_ctrl(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (st_a !== 4'd0) begin failures++; $display("FAIL reset state: got %0d want 0", st_a); end
        checks++;
        if (ctl_a !== e) begin failures++; $display("FAIL reset ctrl: got %h want %h", ctl_a, e); end
        checks++;
        if (ret_a !== 32'd0 || ret_c !== 3'd0) begin
            failures++;
            $display("FAIL reset retired: got %0d/%0d want 0/0", ret_a, ret_c);
        end
        do_reset();
    endtask

    task automatic test_lw();
        sel = 0;
        do_reset();
        run_instr("lw_wait", 6'b100011, 6'($urandom), 1'($urandom), 2, 2);
        run_instr("lw_fast", 6'b100011, 6'($urandom), 1'($urandom), 0, 0);
    endtask

    task automatic test_sw();
        sel = 0;
        do_reset();
        memwrite_cycles = 0;
        run_instr("sw_wait", 6'b101011, 6'($urandom), 1'($urandom), 0, 3);
        checks++;
        if (memwrite_cycles != 4) begin
            failures++;
            $display("FAIL sw memwrite cycles: got %0d want 4", memwrite_cycles);
        end
    endtask

    task automatic test_branch();
        sel = 0;
        do_reset();
        run_instr("beq_taken", 6'b000100, 6'($urandom), 1'b1, 0, 0);
        run_instr("beq_not",   6'b000100, 6'($urandom), 1'b0, 0, 0);
        run_instr("bne_z1",    6'b000101, 6'($urandom), 1'b1, 1, 0);
        run_instr("bne_z0",    6'b000101, 6'($urandom), 1'b0, 0, 0);
        sel = 1;
        do_reset();
        run_instr("beq_base",  6'b000100, 6'($urandom), 1'b1, 0, 0);
        run_instr("bne_base",  6'b000101, 6'($urandom), 1'b0, 0, 0);
    endtask

    task automatic test_rtype();
        sel = 0;
        do_reset();
        run_instr("slt",      6'b000000, 6'b101010, 1'($urandom), 0, 0);
        run_instr("nor_ext",  6'b000000, 6'b100111, 1'($urandom), 0, 0);
        run_instr("sub",      6'b000000, 6'b100010, 1'($urandom), 1, 0);
        run_instr("bad_fn",   6'b000000, 6'b000001, 1'($urandom), 0, 0);
        sel = 1;
        do_reset();
        run_instr("nor_base", 6'b000000, 6'b100111, 1'($urandom), 0, 0);
        run_instr("or_base",  6'b000000, 6'b100101, 1'($urandom), 0, 0);
    endtask

    task automatic test_imm();
        sel = 0;
        do_reset();
        run_instr("lui",  6'b001111, 6'($urandom), 1'($urandom), 0, 0);
        run_instr("andi", 6'b001100, 6'($urandom), 1'($urandom), 0, 0);
        run_instr("addi", 6'b001000, 6'($urandom), 1'($urandom), 0, 0);
        run_instr("ori",  6'b001101, 6'($urandom), 1'($urandom), 0, 0);
        run_instr("jump", 6'b000010, 6'($urandom), 1'($urandom), 0, 0);
    endtask

    task automatic test_random();
        int          new_sel;
        logic [5:0]  o;
        logic [5:0]  f;
        sel = 0;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            new_sel = $urandom_range(0, 1);
            if (new_sel != sel) begin
                sel = new_sel;
                do_reset();
            end
            o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 10)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 5)];
            run_instr("random", o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_midwrite();
        sel = 0;
        do_reset();
        run_instr("pre_j", 6'b000010, 6'($urandom), 1'b0, 0, 0);
        op        = 6'b101011;
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (st_a !== 4'd5 || ctl_a.memwrite !== 1'b1) begin
            failures++;
            $display("FAIL midwrite setup: got state %0d memwrite %0b want 5/1", st_a, ctl_a.memwrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ctl_a.memwrite !== 1'b0) begin
            failures++;
            $display("FAIL midwrite memwrite: got %0b want 0", ctl_a.memwrite);
        end
        checks++;
        if (st_a !== 4'd0 || ret_a !== 32'd0) begin
            failures++;
            $display("FAIL midwrite reset: got state %0d retired %0d want 0/0", st_a, ret_a);
        end
        #1 reset = 1'b0;
        exp_ret = 32'd0;
        @(posedge clk);
        #1;
        run_instr("post_reset", 6'b001000, 6'($urandom), 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        sel = 2;
        do_reset();
        for (int n = 0; n < 8; n++)
            run_instr("wrap_j", 6'b000010, 6'($urandom), 1'($urandom), $urandom_range(0, 1), 0);
        checks++;
        if (obs_ret !== 32'd0) begin
            failures++;
            $display("FAIL wrap retired: got %0d want 0", obs_ret);
        end
        run_instr("wrap_next", 6'b000010, 6'($urandom), 1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_rtype();
        test_imm();
        test_reset_midwrite();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
